// File: rtl/change_dispenser.sv
// Payout stage of the vending credit path: turns (credit, price) into a train of
// single-coin eject pulses for the hopper and reports completion or bad input.
module change_dispenser #(
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 9,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  input  logic [CREDIT_W-1:0] price,
  input  logic                coin_ready,
  output logic                coin_pulse,
  output logic                busy,
  output logic                refund,
  output logic                done,
  output logic                error,
  output logic [CREDIT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    GAP      = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [CREDIT_W-1:0] MAX_V    = CREDIT_W'(MAX_CREDIT);
  localparam logic [3:0]          GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_t              state;
  state_t              state_n;
  logic [3:0]          gap_cnt;
  logic [3:0]          gap_cnt_n;
  logic [CREDIT_W-1:0] remaining_n;
  logic                refund_n;
  logic                coin_pulse_n;
  logic                done_n;
  logic                error_n;

  logic bad_input;
  logic pay_change;

  assign bad_input  = (credit > MAX_V) || (price > MAX_V);
  assign pay_change = (credit >= price);
  assign busy       = (state != IDLE);

  // Hopper handshake: coin_ready is the hopper's ready; a coin is committed only
  // in DISPENSE on an edge where coin_ready=1, and coin_pulse is the registered
  // one-cycle eject that follows. coin_ready is not looked at during GAP.
  always_comb begin
    state_n      = state;
    gap_cnt_n    = gap_cnt;
    remaining_n  = remaining;
    refund_n     = refund;
    coin_pulse_n = 1'b0;
    done_n       = 1'b0;
    error_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (bad_input) begin
            error_n = 1'b1;
          end else if (pay_change) begin
            remaining_n = credit - price;
            refund_n    = 1'b0;
            state_n     = DISPENSE;
          end else begin
            // Price not covered: the whole credit goes back.
            remaining_n = credit;
            refund_n    = 1'b1;
            state_n     = DISPENSE;
          end
        end
      end
      DISPENSE: begin
        if (remaining == '0) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else if (coin_ready) begin
          coin_pulse_n = 1'b1;
          remaining_n  = remaining - CREDIT_W'(1);
          gap_cnt_n    = GAP_LOAD;
          state_n      = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          state_n = DISPENSE;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end
      DONE: begin
        refund_n = 1'b0;
        state_n  = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gap_cnt    <= 4'd0;
      remaining  <= '0;
      refund     <= 1'b0;
      coin_pulse <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      gap_cnt    <= gap_cnt_n;
      remaining  <= remaining_n;
      refund     <= refund_n;
      coin_pulse <= coin_pulse_n;
      done       <= done_n;
      error      <= error_n;
    end
  end

endmodule
